// File: rtl/addsub_pkg.sv
// Shared definitions for the segmented, pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Flags carried behind the sum bits in the last stage payload.
    typedef struct packed {
        logic carry;
        logic ovf;
    } tail_t;

    function automatic int nst(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: resolves one SEG-bit segment and forwards the rest of the beat.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int IDX   = 0,
    localparam int NST_L = nst(WIDTH, SEG),
    localparam bit LAST  = (IDX == NST_L - 32'sd1),
    localparam int RIN   = WIDTH - IDX * SEG,
    localparam int IW    = WIDTH + WIDTH - IDX * SEG + 32'sd1,
    localparam int OW    = WIDTH + WIDTH - (IDX + 32'sd1) * SEG + 32'sd1 + int'(LAST)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    output logic          ready,
    input  logic [IW-1:0] pin,
    output logic          valid,
    input  logic          ready_dn,
    output logic [OW-1:0] pout
);

    // Payload layout: {a_rem, b_rem, low sum bits, carry}; the last stage emits {sum, carry, ovf}.
    logic [RIN-1:0]             a_i;
    logic [RIN-1:0]             b_i;
    logic [SEG-1:0]             seg_s;
    logic [SEG:0]               cy;
    logic [(IDX+1)*SEG-1:0]     sacc;
    logic [OW-1:0]              nxt;
    logic                       valid_r;
    logic [OW-1:0]              pout_r;

    assign a_i   = pin[IW-1 -: RIN];
    assign b_i   = pin[IW-1-RIN -: RIN];
    assign cy[0] = pin[0];

    for (genvar j = 0; j < SEG; j++) begin : g_fa
        full_adder u_fa (
            .a  (a_i[j]),
            .b  (b_i[j]),
            .ci (cy[j]),
            .s  (seg_s[j]),
            .co (cy[j+1])
        );
    end

    if (IDX == 0) begin : g_s0
        assign sacc = seg_s;
    end else begin : g_sn
        assign sacc = {seg_s, pin[IDX*SEG:1]};
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    if (LAST) begin : g_last
        assign nxt = {sacc, cy[SEG], cy[SEG] ^ cy[SEG-1]};
    end else begin : g_mid
        assign nxt = {a_i[RIN-1:SEG], b_i[RIN-1:SEG], sacc, cy[SEG]};
    end

    assign ready = ~valid_r | ready_dn;
    assign valid = valid_r;
    assign pout  = pout_r;

    // Stage register: advances whenever downstream has room; payload only captured for real beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pout_r  <= '0;
        end else if (ready) begin
            valid_r <= valid_in;
            if (valid_in) begin
                pout_r <= nxt;
            end else begin
                pout_r <= pout_r;
            end
        end else begin
            valid_r <= valid_r;
            pout_r  <= pout_r;
        end
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the segment ripple chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor, one SEG-bit segment per stage, valid/ready throughout.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NST = nst(WIDTH, SEG);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        tail_t            tail;
    } result_t;

    if ((WIDTH % SEG) != 0 || NST < 1) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    logic [NST:0]     vld;
    logic [NST:0]     rdy;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    result_t          res;

    // Subtraction becomes a + ~b + ~borrow_in, so c_out = 1 means no borrow.
    assign b_eff    = (sub == MODE_SUB) ? ~b : b;
    assign cin_eff  = (sub == MODE_SUB) ? ~c_in : c_in;

    assign vld[0]   = in_valid;
    assign rdy[NST] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < NST; k++) begin : g_st
        localparam bit LST = (k == NST - 32'sd1);
        localparam int IW  = WIDTH + WIDTH - k * SEG + 32'sd1;
        localparam int OW  = WIDTH + WIDTH - (k + 32'sd1) * SEG + 32'sd1 + int'(LST);

        logic [IW-1:0] pin;
        logic [OW-1:0] pout;

        if (k == 0) begin : g_first
            assign pin = {a, b_eff, cin_eff};
        end else begin : g_next
            assign pin = g_st[k-1].pout;
        end

        addsub_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (vld[k]),
            .ready    (rdy[k]),
            .pin      (pin),
            .valid    (vld[k+1]),
            .ready_dn (rdy[k+1]),
            .pout     (pout)
        );
    end

    assign res       = g_st[NST-1].pout;
    assign out_valid = vld[NST];
    assign sum       = res.sum;
    assign c_out     = res.tail.carry;
    assign ovf       = res.tail.ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub at WIDTH=16, SEG=4.
module tb_pipelined_addsub;

    localparam int W  = 16;
    localparam int SG = 4;
    localparam int NS = W / SG;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    logic [W+1:0] sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .SEG(SG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms, input logic mc);
        int sa, sbv, ua, ub, ci, u, r;
        logic co, ov;
        sa  = $signed(ma);
        sbv = $signed(mb);
        ua  = ma;
        ub  = mb;
        ci  = mc;
        if (!ms) begin
            u  = ua + ub + ci;
            r  = sa + sbv + ci;
            co = (u > 65535);
        end else begin
            u  = ua - ub - ci;
            r  = sa - sbv - ci;
            co = (u >= 0);
        end
        ov = (r > 32767) || (r < -32768);
        return {u[W-1:0], co, ov};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: record accepted beats, compare every presented result against the oldest one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got out_valid=1 sum=0x%0h, want no result", sum);
                end else begin
                    check($sformatf("result%0d", n_out), {14'd0, sum, c_out, ovf}, {14'd0, sb[0]});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, sub, c_in));
            end
        end
    end

    task automatic rand_beat();
        a    = W'($urandom);
        b    = W'($urandom);
        sub  = 1'($urandom_range(0, 1));
        c_in = 1'($urandom_range(0, 1));
    endtask

    // Called just after a rising edge with the pipe empty.
    task automatic send_one(input vec_t v, input int idx);
        int lat;
        a = v.a; b = v.b; sub = v.sub; c_in = v.cin;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), lat, NS);
        check($sformatf("vec%0d_sum", idx), sum, v.s);
        check($sformatf("vec%0d_c_out", idx), c_out, v.co);
        check($sformatf("vec%0d_ovf", idx), ovf, v.ov);
        @(posedge clk); #1;
        check($sformatf("vec%0d_single_pulse", idx), out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, sent, first_low;
        logic acc;

        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_c_out", c_out, 0);
        check("reset_ovf", ovf, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send_one(tbl[i], i);
        end

        // Backpressure: out_ready low for cycles 3..9 while 8 beats are offered.
        base = n_out; sent = 0; first_low = -1;
        rand_beat();
        for (int c = 0; c < 40 && (n_out - base) < 8; c++) begin
            out_ready = !(c >= 3 && c <= 9);
            in_valid = (sent < 8);
            @(negedge clk);
            if (in_valid && !in_ready && first_low < 0) first_low = sent;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                rand_beat();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_beats_before_in_ready_low", first_low, NS);
        check("bp_beats_sent", sent, 8);
        check("bp_results", n_out - base, 8);

        // Full rate: 100 beats back to back.
        base = n_out;
        for (int c = 0; c < 100 + NS; c++) begin
            in_valid = (c < 100);
            if (c < 100) rand_beat();
            @(negedge clk);
            if (c < 100) check($sformatf("fr_in_ready%0d", c), in_ready, 1);
            check($sformatf("fr_out_valid%0d", c), out_valid, (c >= NS));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("fr_results", n_out - base, 100);

        // Reset mid-flight: three beats in, hold the oldest at the output, then reset between edges.
        for (int c = 0; c < 3; c++) begin
            rand_beat();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("rst_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send_one(tbl[0], 8);
        @(posedge clk); #1;
        check("final_scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
